// File: rtl/mem_fifo_sched_pkg.sv
// Shared types and constants for the memory_core FIFO-mode scheduler.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_RUN, ST_DRAIN} sched_st_t;
    localparam logic [1:0] MODE_FIFO = 2'h1;
    localparam int DW_DEF = 16;
endpackage

// File: rtl/mem_fifo_sched_if.sv
// Tile-side handshakes: two write requesters and one read consumer.
interface mem_fifo_sched_if #(parameter int DW = 16);
    logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;

    modport master (output wr0_valid, wr0_data, wr1_valid, wr1_data, rd_ready,
                    input  wr0_ready, wr1_ready, rd_valid, rd_data);
    modport slave  (input  wr0_valid, wr0_data, wr1_valid, wr1_data, rd_ready,
                    output wr0_ready, wr1_ready, rd_valid, rd_data);
endinterface

// File: rtl/mem_fifo_sched_skid.sv
// Small synchronous FIFO catching core read data; pushes while full are dropped.
module mem_fifo_skid #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [PW-1:0]            wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rp_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wp_q] = din;
            wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
        end
        if (do_pop)
            rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_fifo_sched.sv
// Sequencer in front of memory_core in FIFO mode: config, RR write arbitration,
// credit-limited reads into an output skid.
module mem_fifo_sched
    import mem_ctrl_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int CFG_CYC = 2,
    parameter int OBUF_D  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       cfg_depth,
    mem_fifo_sched_if.slave   bus,
    output logic              core_wen,
    output logic [DW-1:0]     core_data_in,
    output logic              core_ren,
    input  logic [DW-1:0]     core_data_out,
    input  logic              core_valid_out,
    input  logic              core_full,
    output logic [15:0]       core_depth,
    output logic [1:0]        core_mode,
    output logic              core_tile_en,
    output logic              core_clk_en,
    output logic [16:0]       occupancy,
    output logic              busy,
    output logic              err
);
    localparam int CW  = $clog2(OBUF_D + 1);
    localparam int CCW = $clog2(CFG_CYC + 1);

    sched_st_t        st_q, st_d;
    logic [CCW-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic [15:0]      depth_q, depth_d;
    logic [16:0]      occ_q, occ_d;
    logic [CW-1:0]    infl_q, infl_d;
    logic             rr_q, rr_d;
    logic             err_q, err_d;

    logic             can_wr, gnt0, gnt1, rd_act;
    logic [CW-1:0]    sk_cnt;
    logic             sk_full, sk_empty;
    logic [DW-1:0]    sk_dout;

    // rr_q=0 favours wr0 on a tie, rr_q=1 favours wr1
    assign can_wr   = (st_q == ST_RUN) && (occ_q < {1'b0, depth_q}) && !core_full;
    assign gnt0     = can_wr && bus.wr0_valid && (!bus.wr1_valid || !rr_q);
    assign gnt1     = can_wr && bus.wr1_valid && (!bus.wr0_valid || rr_q);
    assign rd_act   = (st_q == ST_RUN) || (st_q == ST_DRAIN);
    assign core_wen = gnt0 || gnt1;
    assign core_ren = rd_act && (occ_q != '0) &&
                      (({1'b0, infl_q} + {1'b0, sk_cnt}) < (CW+1)'(OBUF_D));
    assign core_data_in = gnt1 ? bus.wr1_data : (gnt0 ? bus.wr0_data : '0);

    assign bus.wr0_ready = gnt0;
    assign bus.wr1_ready = gnt1;
    assign bus.rd_valid  = !sk_empty;
    assign bus.rd_data   = sk_dout;

    assign core_depth   = depth_q;
    assign core_mode    = MODE_FIFO;
    assign busy         = (st_q != ST_IDLE);
    assign core_tile_en = busy;
    assign core_clk_en  = busy;
    assign occupancy    = occ_q;
    assign err          = err_q;

    mem_fifo_skid #(.DW(DW), .DEPTH(OBUF_D)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (core_valid_out),
        .din   (core_data_out),
        .pop   (bus.rd_ready),
        .dout  (sk_dout),
        .count (sk_cnt),
        .full  (sk_full),
        .empty (sk_empty)
    );

    always_comb begin
        st_d      = st_q;
        cfg_cnt_d = cfg_cnt_q;
        depth_d   = depth_q;
        occ_d     = occ_q;
        infl_d    = infl_q;
        rr_d      = rr_q;
        err_d     = err_q;
        case (st_q)
            ST_IDLE: if (start && cfg_depth != '0) begin
                st_d      = ST_CFG;
                depth_d   = cfg_depth;
                cfg_cnt_d = '0;
            end
            ST_CFG: begin
                if (stop)                                st_d = ST_IDLE;
                else if (cfg_cnt_q == CCW'(CFG_CYC - 1)) st_d = ST_RUN;
                else                                     cfg_cnt_d = cfg_cnt_q + CCW'(1);
            end
            ST_RUN:  if (stop) st_d = ST_DRAIN;
            ST_DRAIN: if (occ_q == '0 && infl_q == '0 && sk_empty) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        if (core_wen && !core_ren)      occ_d = occ_q + 17'd1;
        else if (core_ren && !core_wen) occ_d = occ_q - 17'd1;
        if (core_ren && !core_valid_out)                       infl_d = infl_q + CW'(1);
        else if (!core_ren && core_valid_out && infl_q != '0)  infl_d = infl_q - CW'(1);
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;
        // core reporting full well below our count means the two views diverged
        if ((core_valid_out && infl_q == '0) || (core_valid_out && sk_full) ||
            (busy && core_full && (occ_q + 17'd1 < {1'b0, depth_q})))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q      <= ST_IDLE;
            cfg_cnt_q <= '0;
            depth_q   <= '0;
            occ_q     <= '0;
            infl_q    <= '0;
            rr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            cfg_cnt_q <= cfg_cnt_d;
            depth_q   <= depth_d;
            occ_q     <= occ_d;
            infl_q    <= infl_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_fifo_sched.sv
// Bench for mem_fifo_sched: a memory_core model (1-cycle read latency), directed
// vectors and a randomized session checked against a queue-based model.
module tb_mem_fifo_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] cfg_depth = '0;
    logic        core_wen, core_ren, core_full, core_valid_out;
    logic [15:0] core_data_in, core_data_out, core_depth;
    logic [1:0]  core_mode;
    logic        core_tile_en, core_clk_en, busy, err;
    logic [16:0] occupancy;

    mem_fifo_sched_if #(.DW(16)) bus ();

    mem_fifo_sched #(.DW(16), .CFG_CYC(2), .OBUF_D(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_depth(cfg_depth),
        .bus(bus), .core_wen(core_wen), .core_data_in(core_data_in), .core_ren(core_ren),
        .core_data_out(core_data_out), .core_valid_out(core_valid_out), .core_full(core_full),
        .core_depth(core_depth), .core_mode(core_mode), .core_tile_en(core_tile_en),
        .core_clk_en(core_clk_en), .occupancy(occupancy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // memory_core stand-in: FIFO storage, data one cycle after ren
    logic [15:0] cmem [0:255];
    int          cw, cr, ccnt;
    logic        core_vo, inj;
    logic [15:0] core_dout;
    assign ccnt           = cw - cr;
    assign core_full      = (core_depth != 16'd0) && (ccnt >= int'(core_depth));
    assign core_valid_out = core_vo | inj;
    assign core_data_out  = core_dout;

    always @(posedge clk) begin
        if (!reset) begin
            cw <= 0; cr <= 0; core_vo <= 1'b0; core_dout <= '0;
        end else begin
            core_vo <= core_ren;
            if (core_ren) begin
                core_dout <= cmem[cr[7:0]];
                cr <= cr + 1;
            end
            if (core_wen) begin
                cmem[cw[7:0]] <= core_data_in;
                cw <= cw + 1;
            end
        end
    end

    int          checks = 0, errors = 0;
    logic [15:0] expq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(); @(posedge clk); #1; endtask
    task automatic sett(); #1; endtask

    task automatic pop_chk();
        if (bus.rd_valid && bus.rd_ready) begin
            if (expq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else                  chk("rd_data", {16'd0, bus.rd_data}, {16'd0, expq.pop_front()});
        end
    endtask

    task automatic drain();
        bit done = 0;
        bus.wr0_valid = 0; bus.wr1_valid = 0; bus.rd_ready = 1;
        stop = 1; sett; pop_chk(); step; stop = 0;
        bus.wr1_valid = 1;
        for (int k = 0; k < 80; k++) begin
            sett;
            if (!busy) begin done = 1; break; end
            chk("drain_wr1_ready", {31'd0, bus.wr1_ready}, 32'd0);
            pop_chk();
            step;
        end
        bus.wr1_valid = 0;
        chk("drain_done", {31'd0, done}, 32'd1);
        chk("drain_empty", expq.size(), 32'd0);
        chk("drain_occ", {15'd0, occupancy}, 32'd0);
    endtask

    task automatic begin_session(input logic [15:0] d);
        cfg_depth = d; start = 1; step; start = 0; step; step;
    endtask

    typedef struct {
        logic v0, v1, r0, r1, ren, rdv;
        logic [16:0] occ;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic        mrr, v0, v1, e0, e1, canw, found;
        logic [15:0] d0, d1, depth;

        // both writers always requesting, consumer stalled, depth 4
        tbl[0] = '{1, 1, 1, 0, 0, 0, 17'd0};
        tbl[1] = '{1, 1, 0, 1, 1, 0, 17'd1};
        tbl[2] = '{1, 1, 1, 0, 1, 0, 17'd1};
        tbl[3] = '{1, 1, 0, 1, 0, 1, 17'd1};
        tbl[4] = '{1, 1, 1, 0, 0, 1, 17'd2};
        tbl[5] = '{1, 1, 0, 1, 0, 1, 17'd3};
        tbl[6] = '{1, 1, 0, 0, 0, 1, 17'd4};
        tbl[7] = '{1, 1, 0, 0, 0, 1, 17'd4};

        inj = 0;
        bus.wr0_valid = 0; bus.wr1_valid = 0; bus.rd_ready = 0;
        bus.wr0_data = '0; bus.wr1_data = '0;
        repeat (2) step;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_occ", {15'd0, occupancy}, 32'd0);
        chk("rst_wen_ren", {30'd0, core_wen, core_ren}, 32'd0);
        chk("rst_depth", {16'd0, core_depth}, 32'd0);
        chk("rst_mode", {30'd0, core_mode}, 32'd1);
        chk("rst_en", {30'd0, core_tile_en, core_clk_en}, 32'd0);
        chk("rst_err_rdv", {30'd0, err, bus.rd_valid}, 32'd0);
        reset = 1; step;

        cfg_depth = 0; start = 1; step; start = 0;
        chk("start_depth0_ignored", {31'd0, busy}, 32'd0);

        cfg_depth = 16'd4; start = 1; step; start = 0; cfg_depth = 16'd7;
        bus.wr0_valid = 1; bus.wr1_valid = 1; sett;
        chk("cfg1_ready", {30'd0, bus.wr0_ready, bus.wr1_ready}, 32'd0);
        chk("cfg_depth", {16'd0, core_depth}, 32'd4);
        chk("cfg_busy_en", {29'd0, busy, core_tile_en, core_clk_en}, 32'd7);
        step; sett;
        chk("cfg2_ready", {30'd0, bus.wr0_ready, bus.wr1_ready}, 32'd0);
        chk("cfg2_ren", {31'd0, core_ren}, 32'd0);
        step;

        for (int i = 0; i < 8; i++) begin
            bus.wr0_valid = tbl[i].v0; bus.wr1_valid = tbl[i].v1;
            bus.wr0_data = 16'hA000 + 16'(i); bus.wr1_data = 16'hB000 + 16'(i);
            sett;
            chk($sformatf("tbl%0d_ready", i), {30'd0, bus.wr0_ready, bus.wr1_ready}, {30'd0, tbl[i].r0, tbl[i].r1});
            chk($sformatf("tbl%0d_ren", i), {31'd0, core_ren}, {31'd0, tbl[i].ren});
            chk($sformatf("tbl%0d_rdv", i), {31'd0, bus.rd_valid}, {31'd0, tbl[i].rdv});
            chk($sformatf("tbl%0d_occ", i), {15'd0, occupancy}, {15'd0, tbl[i].occ});
            chk($sformatf("tbl%0d_depth", i), {16'd0, core_depth}, 32'd4);
            if (tbl[i].r0) begin expq.push_back(bus.wr0_data); chk("tbl_din0", {16'd0, core_data_in}, {16'd0, bus.wr0_data}); end
            if (tbl[i].r1) begin expq.push_back(bus.wr1_data); chk("tbl_din1", {16'd0, core_data_in}, {16'd0, bus.wr1_data}); end
            step;
        end

        // drain reads until a cycle with occupancy 2 and a read issue, then write into it
        bus.wr0_valid = 0; bus.wr1_valid = 0; bus.rd_ready = 1; found = 0;
        for (int k = 0; k < 20; k++) begin
            sett; pop_chk();
            if (occupancy == 17'd2 && core_ren) begin found = 1; break; end
            step;
        end
        chk("occ2_ren_seen", {31'd0, found}, 32'd1);
        bus.wr0_valid = 1; bus.wr0_data = 16'hC5A3; sett;
        chk("simul_wr0_ready", {30'd0, bus.wr0_ready, core_ren}, 32'd3);
        if (bus.wr0_ready) expq.push_back(16'hC5A3);
        step; bus.wr0_valid = 0; sett;
        chk("simul_occ", {15'd0, occupancy}, 32'd2);
        drain();

        // randomized session; the last directed grant went to wr0, so wr1 wins the next tie
        mrr = 1;
        depth = 16'($urandom_range(1, 6));
        begin_session(depth);
        for (int n = 0; n < 400; n++) begin
            v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
            d0 = 16'($urandom); d1 = 16'($urandom);
            bus.wr0_valid = v0; bus.wr1_valid = v1; bus.wr0_data = d0; bus.wr1_data = d1;
            bus.rd_ready = 1'($urandom_range(0, 1));
            sett;
            canw = (ccnt < int'(depth));
            e0 = canw && v0 && (!v1 || !mrr);
            e1 = canw && v1 && (!v0 || mrr);
            chk("rnd_ready", {30'd0, bus.wr0_ready, bus.wr1_ready}, {30'd0, e0, e1});
            chk("rnd_occ", {15'd0, occupancy}, ccnt);
            if (e0) begin chk("rnd_din", {16'd0, core_data_in}, {16'd0, d0}); expq.push_back(d0); mrr = 1; end
            if (e1) begin chk("rnd_din", {16'd0, core_data_in}, {16'd0, d1}); expq.push_back(d1); mrr = 0; end
            pop_chk();
            step;
        end
        chk("rnd_err", {31'd0, err}, 32'd0);
        drain();

        // spurious core data with nothing outstanding
        begin_session(16'd8);
        bus.rd_ready = 0; sett;
        chk("pre_inj_err", {31'd0, err}, 32'd0);
        inj = 1; step; inj = 0; sett;
        chk("inj_err", {31'd0, err}, 32'd1);
        repeat (3) step;
        chk("err_sticky", {31'd0, err}, 32'd1);

        // reset in the middle of a loaded session
        bus.wr0_valid = 1; bus.wr0_data = 16'h1234;
        repeat (6) step;
        chk("pre_rst_loaded", {31'd0, (occupancy >= 17'd3)}, 32'd1);
        reset = 0; step; sett;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_occ", {15'd0, occupancy}, 32'd0);
        chk("mid_rst_strobes", {29'd0, core_wen, core_ren, bus.wr0_ready}, 32'd0);
        chk("mid_rst_rdv_err", {30'd0, bus.rd_valid, err}, 32'd0);
        chk("mid_rst_depth", {15'd0, core_tile_en, core_depth}, 32'd0);
        reset = 1; bus.wr0_valid = 0; step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
